// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare PHT scheduler: counter type, FSM states and
// the saturating 2-bit counter update.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_MAX = 2'd3;
  localparam ctr_t CTR_MIN = 2'd0;

  typedef enum logic [1:0] {StIdle, StUpdRd, StUpdWr} state_e;

  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    if (taken) begin
      return (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
    end else begin
      return (ctr == CTR_MIN) ? CTR_MIN : ctr - 2'd1;
    end
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO of resolved-branch updates {idx, taken}; push is dropped when full,
// pop is dropped when empty.
module bp_upd_fifo #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             taken_i,
  input  logic             pop_i,
  output logic [IDX_W-1:0] head_idx_o,
  output logic             head_taken_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

  logic [IDX_W:0] mem_q [DEPTH];
  logic [PtrW:0]  wr_ptr_q, rd_ptr_q;
  logic           do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign head_idx_o   = mem_q[rd_ptr_q[PtrW-1:0]][IDX_W:1];
  assign head_taken_o = mem_q[rd_ptr_q[PtrW-1:0]][0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[PtrW-1:0]] <= {idx_i, taken_i};
        wr_ptr_q                  <= wr_ptr_q + PtrOne;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
    end
  end

endmodule

// File: rtl/bp_pht_scheduler.sv
// gshare pattern history table with a single-port bank shared between fetch lookups and
// queued resolve-side updates, with starvation-bounded arbitration.
module bp_pht_scheduler
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W      = 6,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lk_valid,
  output logic             lk_ready,
  input  logic [IDX_W-1:0] lk_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic [IDX_W-1:0] ghr
);

  localparam int unsigned Entries = 2 ** IDX_W;
  localparam int unsigned StW     = $clog2(STARVE_MAX + 1);
  localparam logic [StW-1:0] StarveMax = StW'(STARVE_MAX);
  localparam logic [StW-1:0] StarveOne = StW'(1);

  ctr_t             pht_q [Entries];
  state_e           state_q;
  logic [IDX_W-1:0] ghr_q, wr_idx_q, pred_idx_q;
  logic             wr_taken_q, pred_valid_q, pred_taken_q;
  ctr_t             hold_q;
  logic [StW-1:0]   starve_q;

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [IDX_W-1:0] head_idx, lk_idx;
  logic             head_taken;
  logic             force_upd, upd_chosen, lk_grant;

  bp_upd_fifo #(
    .IDX_W (IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_upd_fifo (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (upd_valid),
    .idx_i        (upd_idx),
    .taken_i      (upd_taken),
    .pop_i        (fifo_pop),
    .head_idx_o   (head_idx),
    .head_taken_o (head_taken),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  // force_upd is built only from registered state so lk_ready never depends on lk_valid.
  assign force_upd  = fifo_full | (starve_q == StarveMax);
  assign lk_ready   = (state_q == StIdle) & ~force_upd;
  assign upd_chosen = (state_q == StIdle) & (force_upd | (~fifo_empty & ~lk_valid));
  assign lk_grant   = lk_valid & lk_ready;
  assign lk_idx     = lk_pc ^ ghr_q;
  assign upd_ready  = ~fifo_full;
  assign fifo_pop   = (state_q == StUpdRd);

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_idx   = pred_idx_q;
  assign ghr        = ghr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ghr_q        <= '0;
      starve_q     <= '0;
      hold_q       <= CTR_MIN;
      wr_idx_q     <= '0;
      wr_taken_q   <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_idx_q   <= '0;
      for (int i = 0; i < Entries; i++) begin
        pht_q[i] <= CTR_MIN;
      end
    end else begin
      pred_valid_q <= lk_grant;
      if (lk_grant) begin
        pred_idx_q   <= lk_idx;
        pred_taken_q <= pht_q[lk_idx][1];
      end

      if (upd_chosen || fifo_empty) begin
        starve_q <= '0;
      end else if (lk_grant && (starve_q != StarveMax)) begin
        starve_q <= starve_q + StarveOne;
      end

      unique case (state_q)
        StIdle: begin
          if (upd_chosen) state_q <= StUpdRd;
        end
        StUpdRd: begin
          hold_q     <= pht_q[head_idx];
          wr_idx_q   <= head_idx;
          wr_taken_q <= head_taken;
          state_q    <= StUpdWr;
        end
        StUpdWr: begin
          pht_q[wr_idx_q] <= ctr_next(hold_q, wr_taken_q);
          ghr_q           <= {ghr_q[IDX_W-2:0], wr_taken_q};
          state_q         <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_pht_scheduler.sv
// Directed bench for bp_pht_scheduler with hand-computed expectations.
module tb_bp_pht_scheduler;

  localparam int unsigned IDX_W = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             lk_valid = 1'b0;
  logic             lk_ready;
  logic [IDX_W-1:0] lk_pc = '0;
  logic             pred_valid, pred_taken;
  logic [IDX_W-1:0] pred_idx;
  logic             upd_valid = 1'b0;
  logic             upd_ready;
  logic [IDX_W-1:0] upd_idx = '0;
  logic             upd_taken = 1'b0;
  logic [IDX_W-1:0] ghr;

  int errors = 0;
  int checks = 0;
  logic [IDX_W-1:0] ghr_m = '0;

  always #5 clk = ~clk;

  bp_pht_scheduler #(
    .IDX_W      (IDX_W),
    .FIFO_DEPTH (4),
    .STARVE_MAX (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lk_valid   (lk_valid),
    .lk_ready   (lk_ready),
    .lk_pc      (lk_pc),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .pred_idx   (pred_idx),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_idx    (upd_idx),
    .upd_taken  (upd_taken),
    .ghr        (ghr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [IDX_W-1:0] pc,
                        input logic [IDX_W-1:0] exp_idx, input logic exp_taken);
    int n = 0;
    lk_valid = 1'b1;
    lk_pc    = pc;
    while (!lk_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, 32'(n < 20), 1);
    tick();
    lk_valid = 1'b0;
    check({tag, "_pv"}, 32'(pred_valid), 1);
    check({tag, "_idx"}, 32'(pred_idx), 32'(exp_idx));
    check({tag, "_tk"}, 32'(pred_taken), 32'(exp_taken));
  endtask

  task automatic send_upd(input string tag, input logic [IDX_W-1:0] idx, input logic t);
    int n = 0;
    upd_valid = 1'b1;
    upd_idx   = idx;
    upd_taken = t;
    while (!upd_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_urdy"}, 32'(n < 20), 1);
    tick();
    upd_valid = 1'b0;
    ghr_m = {ghr_m[IDX_W-2:0], t};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic exp_nt [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    check("rst_pv", 32'(pred_valid), 0);
    check("rst_pt", 32'(pred_taken), 0);
    check("rst_pidx", 32'(pred_idx), 0);
    check("rst_ghr", 32'(ghr), 0);
    check("rst_lkrdy", 32'(lk_ready), 1);
    check("rst_urdy", 32'(upd_ready), 1);

    // First lookup after reset, then pred outputs hold while pred_valid drops
    lookup("lk0", 6'd5, 6'd5, 1'b0);
    check("lk0_ghr", 32'(ghr), 0);
    tick();
    check("hold_pv", 32'(pred_valid), 0);
    check("hold_idx", 32'(pred_idx), 5);

    // Three taken updates saturate idx 5 at 3
    for (int i = 0; i < 3; i++) send_upd("tk", 6'd5, 1'b1);
    repeat (16) tick();
    check("tk_ghr", 32'(ghr), 32'h07);
    lookup("tk_lk", 6'd2, 6'd5, 1'b1);

    // Not-taken walk 3->2->1->0->0->0, no wrap
    for (int i = 0; i < 5; i++) begin
      send_upd("nt", 6'd5, 1'b0);
      repeat (6) tick();
      lookup($sformatf("nt%0d", i), 6'd5 ^ ghr_m, 6'd5, exp_nt[i]);
    end
    check("nt_ghr", 32'(ghr), 32'h20);
    send_upd("nt_up", 6'd5, 1'b1);
    repeat (6) tick();
    lookup("nt_up_lk", 6'd5 ^ ghr_m, 6'd5, 1'b0);

    // Starvation: lk_valid held high, one queued update forced after 8 grants
    lk_pc     = '0;
    lk_valid  = 1'b1;
    upd_valid = 1'b1;
    upd_idx   = 6'd20;
    upd_taken = 1'b1;
    check("st_urdy", 32'(upd_ready), 1);
    check("st_lkrdy", 32'(lk_ready), 1);
    tick();
    upd_valid = 1'b0;
    ghr_m = {ghr_m[IDX_W-2:0], 1'b1};
    n = 0;
    while (lk_ready && n < 20) begin
      n++;
      tick();
    end
    check("st_grants", 32'(n), 8);
    n = 0;
    while (!lk_ready && n < 20) begin
      n++;
      tick();
    end
    check("st_stall", 32'(n), 3);
    lk_valid = 1'b0;
    repeat (4) tick();
    check("st_ghr", 32'(ghr), 32'(ghr_m));

    // Full queue: lookups stream while four updates enqueue, fifth is held off
    lk_valid  = 1'b1;
    upd_valid = 1'b1;
    upd_idx   = 6'd9;
    upd_taken = 1'b1;
    check("fu_urdy0", 32'(upd_ready), 1);
    repeat (4) tick();
    check("fu_urdy_full", 32'(upd_ready), 0);
    check("fu_lk_full", 32'(lk_ready), 0);
    n = 0;
    while (!upd_ready && n < 20) begin
      n++;
      tick();
    end
    check("fu_hold", 32'(n), 2);
    tick();
    upd_valid = 1'b0;
    check("fu_lk_blk", 32'(lk_ready), 0);
    n = 0;
    while (!lk_ready && n < 20) begin
      n++;
      tick();
    end
    check("fu_lk_resume", 32'(n), 3);
    lk_valid = 1'b0;
    for (int i = 0; i < 5; i++) ghr_m = {ghr_m[IDX_W-2:0], 1'b1};
    repeat (24) tick();
    check("fu_ghr", 32'(ghr), 32'(ghr_m));
    lookup("fu_lk9", 6'd9 ^ ghr_m, 6'd9, 1'b1);
    lookup("fu_lk20", 6'd20 ^ ghr_m, 6'd20, 1'b0);

    // Reset during UPD_WR with two entries still queued
    upd_valid = 1'b1;
    upd_idx   = 6'd9;
    upd_taken = 1'b1;
    check("mr_urdy", 32'(upd_ready), 1);
    repeat (3) tick();
    upd_valid = 1'b0;
    check("mr_busy", 32'(lk_ready), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ghr_m = '0;
    check("mr_pv", 32'(pred_valid), 0);
    check("mr_pidx", 32'(pred_idx), 0);
    check("mr_pt", 32'(pred_taken), 0);
    check("mr_ghr", 32'(ghr), 0);
    check("mr_urdy2", 32'(upd_ready), 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mr_empty%0d", i), 32'(lk_ready), 1);
      tick();
    end
    lookup("mr_lk9", 6'd9, 6'd9, 1'b0);
    lookup("mr_lk20", 6'd20, 6'd20, 1'b0);
    lookup("mr_lk5", 6'd5, 6'd5, 1'b0);
    check("mr_ghr2", 32'(ghr), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
